serial_bus_bridge: RTL
======================

Name: serial_bus_bridge

Overview:
- Host-side debug bridge. Accepts command bytes from the UART receive path, runs reads and writes on the CPU data bus, and returns response bytes on the UART transmit path.
- On the bus it acts as the initiator. The CPU is stalled through RDY/bus arbitration while the bridge owns the bus.
- It lets an external host load and inspect RAM and I/O without CPU firmware.
- It sits between the UART byte interface and the system address decoder.

Parameters:
- TIMEOUT, 20000, inter-byte timeout in clk cycles while a command is partially received (1..65535).
- RD_LAT, 1, cycles from address valid to bus read data valid (registered chip-select/RAM path); allowed values 1 or 2.

Ports:
- clk  input  1  system clock (cpu clock domain).
- rst  input  1  synchronous reset, active-low.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data valid; held until accepted.
- tx_ready  input  1  transmitter accepts a byte when tx_valid & tx_ready.
- bus_req  output  1  bridge requests bus ownership.
- bus_gnt  input  1  ownership granted (CPU halted).
- addr  output  16  bus address, meaningful only while bus_req & bus_gnt.
- dbw  output  8  write data.
- we  output  1  write strobe, one cycle.
- dbr  input  8  bus read data.
- busy  output  1  high whenever state != IDLE.
- rx_overrun  output  1  one-cycle pulse when an rx byte is dropped.

Behaviour:
- Reset (rst low at a clk edge): all outputs 0, state IDLE, counters 0. Reset mid-transaction aborts at once; no pending write completes afterwards.
- Commands, bytes in order:
  - 'W'(0x57) AH AL D: write D to {AH,AL}; response 0x2E.
  - 'R'(0x52) AH AL N: read N bytes (N=0 means 256) from {AH,AL} upward; response is N data bytes.
  - Any other first byte: response 0x3F, then IDLE.
- States: IDLE, GET_AH, GET_AL, GET_ARG, REQ, RD_WAIT, WR, TX, DONE.
  - IDLE -> GET_AH on 'W'/'R'. IDLE -> TX(0x3F) on any other byte.
  - GET_AH -> GET_AL -> GET_ARG, each advancing on rx_valid.
  - GET_ARG -> REQ, with bus_req=1.
  - REQ waits for bus_gnt. On grant:
    - Write: WR drives addr/dbw with we=1 for exactly one cycle, bus_req drops the next cycle, then TX(0x2E).
    - Read: RD_WAIT drives addr for RD_LAT cycles and captures dbr on the last of them. bus_req drops the cycle after capture, then TX(data).
  - TX: tx_valid=1 and tx_data stable until tx_ready is sampled high. Then:
    - READ with remaining count > 0: addr increments, wrapping 0xFFFF -> 0x0000, back to REQ.
    - Otherwise: DONE -> IDLE in 1 cycle.
- Bus is requested per access and released between bytes of a block read. bus_req never stays high while waiting on tx_ready.
- Timeout counter:
  - Cleared on every accepted rx byte; runs only in GET_AH/GET_AL/GET_ARG.
  - When it reaches TIMEOUT, state goes to IDLE silently with no response.
- rx bytes arriving in REQ, RD_WAIT, WR, TX or DONE are dropped with a rx_overrun pulse. In IDLE and GET_* states every byte is accepted.
- rx_valid in the same cycle as the timeout expiry: the byte is accepted and the timeout is ignored.
- bus_gnt deasserted mid-access is a protocol error the bench must not generate. The design holds its current state.
- Latency:
  - Last command byte to bus_req: 1 cycle.
  - bus_gnt to we: 1 cycle.
  - Capture to tx_valid: 1 cycle.

Optional Feature:
- Macro: SERIAL_BUS_BRIDGE_CHECKSUM_EN.
- Defined: after the final response byte of every command ('.', '?', or the last read byte), one extra byte is sent. It is the XOR of all command bytes received for that command and all response bytes sent. The 0x3F error response checksum equals 0x3F ^ cmd.
- Undefined: no checksum byte; logic absent.

Test Plan:
- Write: rx 57 12 34 A5, grant immediate -> one-cycle we with addr=0x1234, dbw=0xA5; tx 0x2E; busy back to 0.
- Read with delayed grant: rx 52 80 00 01, bus_gnt delayed 5 cycles, dbr=0x3C at the capture cycle -> we stays 0; tx 0x3C; bus_req high exactly REQ..capture+1.
- Block read with wrap and backpressure: rx 52 FF FE 03, tx_ready held low 10 cycles per byte -> addrs FFFE, FFFF, 0000; three tx bytes; bus_req low during every tx stall.
- Bad command and overrun: rx 0x41 -> tx 0x3F. rx byte injected during TX -> rx_overrun pulse, byte ignored, next command is parsed correctly.
- Timeout and reset: rx 57 12, then idle for TIMEOUT cycles -> IDLE, no tx, no bus_req. Then rst low during WR of a new write -> all outputs 0 next cycle, we never re-asserts.
- Checksum (with SERIAL_BUS_BRIDGE_CHECKSUM_EN): write 57 00 10 FF -> tx 2E then 0x57^0x00^0x10^0xFF^0x2E = 0x96.

Source files
------------

// File: rtl/serial_bus_bridge_if.sv
// serial_bus_bridge_if: UART byte stream and CPU-bus initiator signals of the debug bridge.
// The master modport is the bridge; the slave modport is the UART/bus side it talks to.
interface serial_bus_bridge_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        bus_req;
   logic        bus_gnt;
   logic [15:0] addr;
   logic [7:0]  dbw;
   logic        we;
   logic [7:0]  dbr;
   logic        busy;
   logic        rx_overrun;

   modport master (
      input  rx_data, rx_valid, tx_ready, bus_gnt, dbr,
      output tx_data, tx_valid, bus_req, addr, dbw, we, busy, rx_overrun
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, bus_gnt, dbr,
      input  tx_data, tx_valid, bus_req, addr, dbw, we, busy, rx_overrun
   );
endinterface

// File: rtl/serial_bus_bridge.sv
// serial_bus_bridge: host debug bridge turning UART command bytes into CPU-bus writes/reads.
// Optional trailing XOR checksum byte per command: define SERIAL_BUS_BRIDGE_CHECKSUM_EN.
module serial_bus_bridge #(
   parameter int unsigned TIMEOUT = 20000,
   parameter int unsigned RD_LAT  = 1
) (
   input logic                 clk,
   input logic                 rst,
   serial_bus_bridge_if.master bus
);
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      GET_AH  = 4'd1,
      GET_AL  = 4'd2,
      GET_ARG = 4'd3,
      REQ     = 4'd4,
      RD_WAIT = 4'd5,
      WR      = 4'd6,
      TX      = 4'd7,
      DONE    = 4'd8
   } state_t;

   localparam logic [7:0]  CMD_W    = 8'h57;
   localparam logic [7:0]  CMD_R    = 8'h52;
   localparam logic [7:0]  RSP_OK   = 8'h2E;
   localparam logic [7:0]  RSP_ERR  = 8'h3F;
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [1:0]  LAT_LAST = 2'(RD_LAT - 1);

   state_t      state_r, state_s;
   logic [15:0] addr_r, addr_s;
   logic [7:0]  dbw_r, dbw_s;
   logic        we_r, we_s;
   logic        bus_req_r, bus_req_s;
   logic [7:0]  tx_data_r, tx_data_s;
   logic        tx_valid_r, tx_valid_s;
   logic        busy_r, busy_s;
   logic        rx_overrun_r, rx_overrun_s;
   logic        is_rd_r, is_rd_s;
   logic [8:0]  cnt_r, cnt_s;
   logic [15:0] to_cnt_r, to_cnt_s;
   logic [1:0]  lat_r, lat_s;
   logic        in_get_s;
   logic        to_hit_s;
`ifdef SERIAL_BUS_BRIDGE_CHECKSUM_EN
   logic [7:0]  cks_r, cks_s;
   logic        cks_sent_r, cks_sent_s;

   function automatic logic [7:0] cks_acc(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction
`endif

   assign bus.addr       = addr_r;
   assign bus.dbw        = dbw_r;
   assign bus.we         = we_r;
   assign bus.bus_req    = bus_req_r;
   assign bus.tx_data    = tx_data_r;
   assign bus.tx_valid   = tx_valid_r;
   assign bus.busy       = busy_r;
   assign bus.rx_overrun = rx_overrun_r;

   // Next-state and next-output logic for the command FSM.
   always_comb begin
      state_s    = state_r;
      addr_s     = addr_r;
      dbw_s      = dbw_r;
      we_s       = we_r;
      bus_req_s  = bus_req_r;
      tx_data_s  = tx_data_r;
      tx_valid_s = tx_valid_r;
      is_rd_s    = is_rd_r;
      cnt_s      = cnt_r;
      lat_s      = lat_r;
      in_get_s   = (state_r == GET_AH) || (state_r == GET_AL) || (state_r == GET_ARG);
      to_hit_s   = (to_cnt_r >= TO_LAST);

      // Timeout runs only while a command is partially received; any accepted byte restarts it.
      if (in_get_s && !bus.rx_valid && !to_hit_s) begin
         to_cnt_s = to_cnt_r + 16'd1;
      end else begin
         to_cnt_s = 16'd0;
      end

      if (bus.rx_valid && !in_get_s && (state_r != IDLE)) begin
         rx_overrun_s = 1'b1;
      end else begin
         rx_overrun_s = 1'b0;
      end

`ifdef SERIAL_BUS_BRIDGE_CHECKSUM_EN
      if (bus.rx_valid && (state_r == IDLE)) begin
         cks_s      = bus.rx_data;
         cks_sent_s = 1'b0;
      end else if (bus.rx_valid && in_get_s) begin
         cks_s      = cks_acc(cks_r, bus.rx_data);
         cks_sent_s = cks_sent_r;
      end else if (bus.tx_ready && (state_r == TX)) begin
         cks_s      = cks_acc(cks_r, tx_data_r);
         cks_sent_s = cks_sent_r;
      end else begin
         cks_s      = cks_r;
         cks_sent_s = cks_sent_r;
      end
`endif

      case (state_r)
         IDLE: begin
            if (bus.rx_valid && ((bus.rx_data == CMD_W) || (bus.rx_data == CMD_R))) begin
               is_rd_s = (bus.rx_data == CMD_R);
               state_s = GET_AH;
            end else if (bus.rx_valid) begin
               is_rd_s    = 1'b0;
               tx_data_s  = RSP_ERR;
               tx_valid_s = 1'b1;
               state_s    = TX;
            end else begin
               state_s = IDLE;
            end
         end
         GET_AH: begin
            if (bus.rx_valid) begin
               addr_s[15:8] = bus.rx_data;
               state_s      = GET_AL;
            end else if (to_hit_s) begin
               state_s = IDLE;
            end else begin
               state_s = GET_AH;
            end
         end
         GET_AL: begin
            if (bus.rx_valid) begin
               addr_s[7:0] = bus.rx_data;
               state_s     = GET_ARG;
            end else if (to_hit_s) begin
               state_s = IDLE;
            end else begin
               state_s = GET_AL;
            end
         end
         GET_ARG: begin
            if (bus.rx_valid) begin
               dbw_s     = bus.rx_data;
               cnt_s     = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
               bus_req_s = 1'b1;
               state_s   = REQ;
            end else if (to_hit_s) begin
               state_s = IDLE;
            end else begin
               state_s = GET_ARG;
            end
         end
         REQ: begin
            if (bus.bus_gnt && is_rd_r) begin
               lat_s   = 2'd0;
               state_s = RD_WAIT;
            end else if (bus.bus_gnt) begin
               we_s    = 1'b1;
               state_s = WR;
            end else begin
               state_s = REQ;
            end
         end
         RD_WAIT: begin
            // A lost grant mid-access freezes the access rather than sampling a bus we do not own.
            if (bus.bus_gnt && (lat_r == LAT_LAST)) begin
               tx_data_s  = bus.dbr;
               tx_valid_s = 1'b1;
               bus_req_s  = 1'b0;
               state_s    = TX;
            end else if (bus.bus_gnt) begin
               lat_s = lat_r + 2'd1;
            end else begin
               state_s = RD_WAIT;
            end
         end
         WR: begin
            if (bus.bus_gnt) begin
               we_s       = 1'b0;
               bus_req_s  = 1'b0;
               tx_data_s  = RSP_OK;
               tx_valid_s = 1'b1;
               state_s    = TX;
            end else begin
               state_s = WR;
            end
         end
         TX: begin
            if (bus.tx_ready && is_rd_r && (cnt_r > 9'd1)) begin
               cnt_s      = cnt_r - 9'd1;
               addr_s     = addr_r + 16'd1;
               bus_req_s  = 1'b1;
               tx_valid_s = 1'b0;
               state_s    = REQ;
            end else if (bus.tx_ready) begin
`ifdef SERIAL_BUS_BRIDGE_CHECKSUM_EN
               if (!cks_sent_r) begin
                  tx_data_s  = cks_acc(cks_r, tx_data_r);
                  cks_sent_s = 1'b1;
                  state_s    = TX;
               end else begin
                  tx_valid_s = 1'b0;
                  state_s    = DONE;
               end
`else
               tx_valid_s = 1'b0;
               state_s    = DONE;
`endif
            end else begin
               state_s = TX;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      busy_s = (state_s != IDLE);
   end

   // State and output registers; reset clears everything and abandons any access.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= IDLE;
         addr_r       <= 16'd0;
         dbw_r        <= 8'd0;
         we_r         <= 1'b0;
         bus_req_r    <= 1'b0;
         tx_data_r    <= 8'd0;
         tx_valid_r   <= 1'b0;
         busy_r       <= 1'b0;
         rx_overrun_r <= 1'b0;
         is_rd_r      <= 1'b0;
         cnt_r        <= 9'd0;
         to_cnt_r     <= 16'd0;
         lat_r        <= 2'd0;
`ifdef SERIAL_BUS_BRIDGE_CHECKSUM_EN
         cks_r        <= 8'd0;
         cks_sent_r   <= 1'b0;
`endif
      end else begin
         state_r      <= state_s;
         addr_r       <= addr_s;
         dbw_r        <= dbw_s;
         we_r         <= we_s;
         bus_req_r    <= bus_req_s;
         tx_data_r    <= tx_data_s;
         tx_valid_r   <= tx_valid_s;
         busy_r       <= busy_s;
         rx_overrun_r <= rx_overrun_s;
         is_rd_r      <= is_rd_s;
         cnt_r        <= cnt_s;
         to_cnt_r     <= to_cnt_s;
         lat_r        <= lat_s;
`ifdef SERIAL_BUS_BRIDGE_CHECKSUM_EN
         cks_r        <= cks_s;
         cks_sent_r   <= cks_sent_s;
`endif
      end
   end
endmodule
